fp_normalize_round: RTL and testbench

- Multi-cycle post-adder stage: takes the raw sign/exponent/extended significand produced by the FP add datapath and emits a packed IEEE-754 single-precision fp_t.
- Normalizes iteratively, one bit per cycle, then rounds to nearest-even.
- Flags overflow (result forced to infinity) and underflow (flush to zero; denormals are not produced).
- Sits between the add/sub datapath and the FP register-file writeback, with valid/ready handshakes on both sides.

---
 rtl/fp_normalize_round.sv | 140 ++++++++++++++
 tb/tb_fp_normalize_round.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_round.sv
// Post-adder normalize/round stage: iterative one-bit-per-cycle normalization, RNE rounding, packed fp_t out.
// Latency 1 (zero) to 3+shifts cycles; in_ready only in IDLE, result held while out_ready is low.
package fp_normalize_round_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] significand;
  } fp_t;
endpackage

module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output fp_t               out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_sign;
  logic [EXP_W:0]    r_exp;
  logic [MANT_W-1:0] r_mant;
  fp_t               r_result;
  logic              r_ovf;
  logic              r_unf;
  logic              r_out_valid;

  logic              w_round_up;
  logic [24:0]       w_sum;
  logic [EXP_W:0]    w_exp_rnd;
  logic [22:0]       w_frac;
  logic [MANT_W-1:0] w_mant_rsh;
  logic [MANT_W-1:0] w_mant_lsh;

  // Right shift folds the dropped bit into sticky; left shift keeps sticky pinned at bit0.
  assign w_mant_rsh = {1'b0, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};
  assign w_mant_lsh = {r_mant[MANT_W-2:1], 1'b0, r_mant[0]};

  assign w_round_up = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_sum      = {1'b0, r_mant[26:3]} + {24'b0, w_round_up};
  assign w_exp_rnd  = r_exp + {{EXP_W{1'b0}}, w_sum[24]};
  assign w_frac     = w_sum[24] ? w_sum[23:1] : w_sum[22:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next_state = (in_mant == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (r_mant[27] || r_mant[26])          w_next_state = S_ROUND;
        else if (r_exp <= (EXP_W+1)'(1))       w_next_state = S_DONE;
        else                                   w_next_state = S_SHIFT;
      end
      S_ROUND: w_next_state = S_DONE;
      S_DONE: begin
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            r_exp  <= {1'b0, in_exponent};
            r_mant <= in_mant;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            if (in_mant == '0) r_result <= '{sign: in_sign, exponent: 8'h00, significand: 23'h0};
          end
        end
        S_SHIFT: begin
          if (r_mant[27]) begin
            r_mant <= w_mant_rsh;
            r_exp  <= r_exp + (EXP_W+1)'(1);
          end else if (r_mant[26]) begin
            r_mant <= r_mant;
          end else if (r_exp <= (EXP_W+1)'(1)) begin
            r_result <= '{sign: r_sign, exponent: 8'h00, significand: 23'h0};
            r_unf    <= 1'b1;
          end else begin
            r_mant <= w_mant_lsh;
            r_exp  <= r_exp - (EXP_W+1)'(1);
          end
        end
        S_ROUND: begin
          if (w_exp_rnd >= (EXP_W+1)'(255)) begin
            r_result <= '{sign: r_sign, exponent: 8'hFF, significand: 23'h0};
            r_ovf    <= 1'b1;
          end else begin
            r_result <= '{sign: r_sign, exponent: w_exp_rnd[7:0], significand: w_frac};
          end
        end
        default: begin
          r_mant <= r_mant;
        end
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = r_out_valid;
  assign out_result    = r_result;
  assign out_overflow  = r_ovf;
  assign out_underflow = r_unf;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: vector table through a scoreboard queue, plus hold and mid-op reset sequences.
module tb_fp_normalize_round;
  import fp_normalize_round_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  fp_t         out_result;
  logic        out_overflow;
  logic        out_underflow;

  fp_normalize_round #(.MANT_W(28), .EXP_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exponent = e; in_mant = m;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic push(input vec_t v);
    exp_t x;
    x.res = v.res; x.ovf = v.ovf; x.unf = v.unf; x.lat = v.lat;
    sb.push_back(x);
  endtask

  // Called right after the accept edge; that edge counts as latency 1.
  task automatic collect(input string name);
    int   lat;
    exp_t x;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      chk({name, "_valid_timeout"}, 32'(out_valid), 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      chk({name, "_no_expected"}, 32'(sb.size()), 32'd1);
      return;
    end
    x = sb.pop_front();
    chk({name, "_result"}, out_result, x.res);
    chk({name, "_ovf"}, 32'(out_overflow), 32'(x.ovf));
    chk({name, "_unf"}, 32'(out_underflow), 32'(x.unf));
    chk({name, "_latency"}, 32'(lat), 32'(x.lat));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit ok;
    drive(v.s, v.e, v.m, ok);
    if (ok) begin
      push(v);
      collect(name);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit ok;
    vecs[0]  = '{1'b0, 8'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b0, 8'd127, 28'h0400000, 32'h3D800000, 1'b0, 1'b0, 7};
    vecs[4]  = '{1'b0, 8'd2,   28'h0000010, 32'h00000000, 1'b0, 1'b1, 3};
    vecs[5]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[6]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 3};
    vecs[7]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b1, 8'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b1, 8'd130, 28'h6000000, 32'hC1400000, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, 8'd127, 28'h8000009, 32'h40000001, 1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 8'd127, 28'h0000002, 32'h33000000, 1'b0, 1'b0, 28};
    vecs[12] = '{1'b1, 8'd3,   28'h0800000, 32'h80000000, 1'b0, 1'b1, 4};
    vecs[13] = '{1'b1, 8'd254, 28'h7FFFFFC, 32'hFF800000, 1'b1, 1'b0, 3};

    reset_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0; in_mant = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
    chk("rst_unf", 32'(out_underflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Result must stay put and new operands be refused while downstream stalls.
    out_ready = 1'b0;
    drive(vecs[9].s, vecs[9].e, vecs[9].m, ok);
    if (ok) begin
      push(vecs[9]);
      collect("hold");
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b1; in_exponent = 8'd0; in_mant = 28'h0;
        @(posedge clk);
        #1;
        chk("hold_result", out_result, vecs[9].res);
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b1;
    run_vec(vecs[1], "after_hold");

    // Reset in the middle of a left-shift sequence discards the operation.
    drive(vecs[3].s, vecs[3].e, vecs[3].m, ok);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_result", out_result, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    run_vec(vecs[6], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
